// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and defaults for the sequential multiplier
package mult_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   localparam int DEFAULT_MULT_WIDTH = 8;
endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: WIDTH-bit ripple-carry adder built from full-adder cells
module ripple_adder_n
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_MULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0] w_c;
   assign w_c[0] = cin;
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_fa
         assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate
   assign cout = w_c[WIDTH];
endmodule

// File: rtl/seq_mult_n.sv
// seq_mult_n: sequential shift-and-add multiplier, unsigned or two's-complement, WIDTH+1 cycles per product
module seq_mult_n
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_en,
   input  logic [WIDTH-1:0]   num1,
   input  logic [WIDTH-1:0]   num2,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   state_t               r_state, w_next;
   logic                 r_neg;
   logic [WIDTH-1:0]     r_mcand, r_hi, r_lo;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_result;
   logic                 w_accept, w_last, w_cout;
   logic [WIDTH-1:0]     w_mag1, w_mag2, w_addend, w_sum;
   logic [2*WIDTH-1:0]   w_prod;
   assign w_accept = start & ready;
   assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
   assign w_mag1   = (signed_en & num1[WIDTH-1]) ? ~num1 + 1'b1 : num1;
   assign w_mag2   = (signed_en & num2[WIDTH-1]) ? ~num2 + 1'b1 : num2;
   assign w_addend = r_lo[0] ? r_mcand : '0;
   assign w_prod   = {r_hi, r_lo};
   assign result   = r_result;
   ripple_adder_n #(.WIDTH(WIDTH)) u_add (
      .a    (r_hi),
      .b    (w_addend),
      .cin  (1'b0),
      .sum  (w_sum),
      .cout (w_cout)
   );
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   // next state and handshake outputs decoded from the current state
   always_comb begin
      w_next = r_state;
      ready  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            ready  = 1'b1;
            w_next = start ? CALC : IDLE;
         end
         CALC: begin
            busy   = 1'b1;
            w_next = w_last ? FIX : CALC;
         end
         FIX: begin
            busy   = 1'b1;
            w_next = DONE;
         end
         DONE: begin
            ready  = 1'b1;
            done   = 1'b1;
            w_next = start ? CALC : DONE;
         end
         default: w_next = IDLE;
      endcase
   end
   // datapath: latch magnitudes on accept, add-and-shift while calculating, apply sign in FIX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_neg   <= signed_en & (num1[WIDTH-1] ^ num2[WIDTH-1]);
         r_mcand <= w_mag1;
         r_lo    <= w_mag2;
         r_hi    <= '0;
         r_cnt   <= '0;
      end else if (r_state == CALC) begin
         r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
         r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX) begin
         r_result <= r_neg ? ~w_prod + 1'b1 : w_prod;
      end
   end
endmodule

// File: doc/seq_mult_n.md
Name: seq_mult_n

Overview:
Parametrised sequential shift-and-add multiplier; next generation of the 2-bit combinational array multiplier. Multiplies two WIDTH-bit operands, unsigned or two's-complement (per-operation mode), over WIDTH+1 cycles using one WIDTH-bit adder. Start/ready/done handshake; result held until the next accepted start. Sits in the lab datapath wherever a multi-bit product is needed without a full array.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; accepted only when ready=1
signed_en  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
num1  in  WIDTH  multiplicand, sampled on accepted start
num2  in  WIDTH  multiplier, sampled on accepted start
ready  out  1  1 in IDLE or DONE
busy  out  1  1 in CALC or FIX
done  out  1  level; 1 while in DONE (result valid)
result  out  2*WIDTH  product; valid while done=1

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation): state=IDLE, result=0, done=0, busy=0, ready=1, all internal registers 0. No partial result survives.
- States: IDLE, CALC, FIX, DONE.
- Acceptance: edge where start=1 and ready=1. start while busy=1 is ignored, with no effect on operands or state.
- On acceptance (edge k): latch sign flag neg = signed_en & (num1[W-1] ^ num2[W-1]); latch magnitudes (|x| if signed_en and MSB=1, else x, as WIDTH-bit unsigned; -2^(W-1) -> 2^(W-1), fits). acc=0, count=0, state=CALC, done=0.
- CALC, edges k+1..k+WIDTH: if multiplier LSB=1, upper half of acc += multiplicand (WIDTH-bit add, carry kept as acc bit 2W-1 after shift); {carry,acc,multiplier} shifted right 1; count++. After the WIDTH-th iteration -> FIX.
- FIX, edge k+WIDTH+1: result = neg ? -acc : acc (2W-bit two's complement); state=DONE; done=1.
- Latency: done rises exactly WIDTH+1 edges after the acceptance edge (9 cycles at WIDTH=8).
- DONE: result and done held indefinitely. start=1 -> accepted, new operands latched, done=0 on that edge, CALC; result register holds the old value, but it is not valid while done=0.
- Width rules: no overflow is possible. Unsigned max (2^W-1)^2 fits 2W bits. Signed max (-2^(W-1))^2 = 2^(2W-2) fits 2W signed.
- Zero operand with negative sign: -0 -> 0. result must never be 2^(2W-1) in that case.
- signed_en=0: operand MSBs are data bits, neg=0.
- Input changes after acceptance have no effect until the next acceptance.

Decomposition:
- Shared package mult_pkg: state enum (IDLE, CALC, FIX, DONE), 2-bit state typedef, constant DEFAULT_MULT_WIDTH=8.
- One sub-module: ripple_adder_n (parameter WIDTH; inputs a, b, cin; outputs sum, cout). Built as a chain of full-adder cells and used for the accumulate step. The FIX negation uses a separate inline increment, not this adder.

Test Plan:
- WIDTH=8, unsigned, 13*11: start pulse -> busy for 9 edges, then done=1, result=16'h008F. Held for 5 idle cycles.
- Unsigned 255*255 -> result=16'hFE01. Unsigned 0*200 -> 16'h0000.
- signed_en=1: (-7)*5 (8'hF9, 8'h05) -> 16'hFFDD. (-128)*(-128) -> 16'h4000. (-128)*1 -> 16'hFF80. (-5)*0 -> 16'h0000.
- start held high during CALC with new operands (3*3) -> ignored. First product completes unchanged at the original latency, then re-accepted in DONE: 3*3 -> 16'h0009.
- Back-to-back: start asserted on the cycle done first rises -> done drops next edge and the second result appears 9 edges later. ready=1 is seen only in DONE/IDLE.
- rst_n asserted asynchronously mid-CALC (between clock edges) -> outputs immediately result=0, done=0, busy=0, ready=1. After release, 6*7 -> 16'h002A with normal latency.
- Random scoreboard, 2000 ops, WIDTH=8 and WIDTH=5, both modes, compared against the reference product.
